partition_rr_arbiter: RTL

//  - NUM_IN-way round-robin merge of tuple streams into one output stream.
//  - Accepts only tuples whose partition field in_tag[PART_LSB +: PART_BITS] == ID.
//  - Used at each partition stage of the join to share one downstream builder/prober between NUM_IN upstream lanes.
//  - Signals end-of-stream once every lane reports last_processed and all accepted tuples are delivered.

---
 rtl/partition_rr_arbiter_pkg.sv | 22 ++
 rtl/partition_rr_arbiter_if.sv | 51 +++++
 rtl/partition_rr_arbiter_rr_pick.sv | 35 +++
 rtl/partition_rr_arbiter.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/partition_rr_arbiter_pkg.sv
// Shared types for the partition round-robin arbiter.
// Tuple bundle, FSM states and field widths.
package phj_pkg;

    localparam int TAG_W    = 32;
    localparam int SERIAL_W = 64;
    localparam int DATA_W   = 64;

    typedef enum logic [1:0] {
        S_INIT,
        S_WORK,
        S_DONE
    } arb_state_t;

    typedef struct packed {
        logic [DATA_W-1:0]   data;
        logic [TAG_W-1:0]    tag;
        logic [SERIAL_W-1:0] serialnum;
        logic                was_joined;
    } tuple_t;

endpackage

// File: rtl/partition_rr_arbiter_if.sv
// Lane/output bundle for partition_rr_arbiter.
// PHJ_ARB_STATS_EN adds per-lane grant counters.
interface partition_rr_arbiter_if
    import phj_pkg::*;
#(
    parameter int INPUT_SIZE = 64,
    parameter int NUM_IN     = 4
) ();

    logic [NUM_IN-1:0]            in_valid;
    logic [NUM_IN-1:0]            in_ready;
    logic [NUM_IN*INPUT_SIZE-1:0] in_data;
    logic [NUM_IN*TAG_W-1:0]      in_tag;
    logic [NUM_IN*SERIAL_W-1:0]   in_serialnum;
    logic [NUM_IN-1:0]            in_was_joined;
    logic [NUM_IN-1:0]            in_last_processed;
    logic                         ready_4_output;
    logic                         out_valid;
    logic [INPUT_SIZE-1:0]        out_data;
    logic [TAG_W-1:0]             out_tag;
    logic [SERIAL_W-1:0]          out_serialnum;
    logic                         out_was_joined;
    logic                         out_last_processed;
    logic                         busy;
`ifdef PHJ_ARB_STATS_EN
    logic [NUM_IN-1:0][31:0]      grant_count;
`endif

    modport slave (
        input  in_valid, in_data, in_tag, in_serialnum,
        input  in_was_joined, in_last_processed, ready_4_output,
        output in_ready, out_valid, out_data, out_tag,
        output out_serialnum, out_was_joined,
        output out_last_processed, busy
`ifdef PHJ_ARB_STATS_EN
        , output grant_count
`endif
    );

    modport master (
        output in_valid, in_data, in_tag, in_serialnum,
        output in_was_joined, in_last_processed, ready_4_output,
        input  in_ready, out_valid, out_data, out_tag,
        input  out_serialnum, out_was_joined,
        input  out_last_processed, busy
`ifdef PHJ_ARB_STATS_EN
        , input grant_count
`endif
    );

endinterface

// File: rtl/partition_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first request at or
// after ptr, found by priority-encoding a rotated copy.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] index,
    output logic                 any
);

    localparam int IW = $clog2(N);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   win;
    logic [IW:0]    off;
    logic [IW:0]    pos;

    // rotate so ptr lands at bit 0, take lowest set bit, unrotate
    always_comb begin
        dbl = {req, req};
        win = N'(dbl >> ptr);
        any = |req;
        off = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (win[k]) off = (IW+1)'(k);
        end
        pos = {1'b0, ptr} + off;
        if (pos >= (IW+1)'(N)) pos = pos - (IW+1)'(N);
        index = pos[IW-1:0];
        grant = any ? (N'(1) << index) : '0;
    end

endmodule

// File: rtl/partition_rr_arbiter.sv
// Round-robin merge of NUM_IN tuple lanes, partition-filtered.
// Optional macro PHJ_ARB_STATS_EN adds grant_count outputs.
module partition_rr_arbiter
    import phj_pkg::*;
#(
    parameter int INPUT_SIZE = 64,
    parameter int NUM_IN     = 4,
    parameter int PART_BITS  = 1,
    parameter int PART_LSB   = 0,
    parameter logic [PART_BITS-1:0] ID = '0
) (
    input  logic clk,
    input  logic reset,
    partition_rr_arbiter_if.slave bus
);

    localparam int IW = $clog2(NUM_IN);

    arb_state_t        state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    tuple_t            out_q, out_d;
    logic              ov_q, ov_d;

    logic [NUM_IN-1:0] req;
    logic [NUM_IN-1:0] grant;
    logic [NUM_IN-1:0] lane_done;
    logic [NUM_IN-1:0] in_ready;
    logic [IW-1:0]     idx;
    logic              any;
    logic              adv;
    logic              work;
    tuple_t            sel;

    // per-lane request (partition match) and end-of-stream status
    always_comb begin
        req       = '0;
        lane_done = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            req[i] = bus.in_valid[i] &
                (bus.in_tag[i*TAG_W + PART_LSB +: PART_BITS] == ID);
            lane_done[i] = ~bus.in_valid[i] & bus.in_last_processed[i];
        end
    end

    rr_pick #(.N(NUM_IN)) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .grant (grant),
        .index (idx),
        .any   (any)
    );

    // one-hot mux of the granted lane's fields
    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant[i]) begin
                sel.data       = sel.data |
                    bus.in_data[i*INPUT_SIZE +: INPUT_SIZE];
                sel.tag        = sel.tag |
                    bus.in_tag[i*TAG_W +: TAG_W];
                sel.serialnum  = sel.serialnum |
                    bus.in_serialnum[i*SERIAL_W +: SERIAL_W];
                sel.was_joined = sel.was_joined |
                    bus.in_was_joined[i];
            end
        end
    end

    assign adv      = bus.ready_4_output | ~ov_q;
    assign work     = (state_q == S_WORK);
    assign in_ready = (adv & work) ? grant : '0;

    // next-state: load on grant, empty on idle advance, detect end
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        out_d   = out_q;
        ov_d    = ov_q;
        unique case (state_q)
            S_INIT: state_d = S_WORK;
            S_WORK: begin
                if (adv) begin
                    ov_d = any;
                    if (any) begin
                        out_d = sel;
                        ptr_d = (idx == IW'(NUM_IN - 1)) ?
                            '0 : idx + IW'(1);
                    end
                end
                if ((&lane_done) && adv) state_d = S_DONE;
            end
            S_DONE: state_d = S_DONE;
            default: state_d = S_INIT;
        endcase
    end

    // state, pointer and output register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_INIT;
            ptr_q   <= '0;
            out_q   <= '0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            out_q   <= out_d;
            ov_q    <= ov_d;
        end
    end

    assign bus.in_ready           = in_ready;
    assign bus.out_valid          = ov_q;
    assign bus.out_data           = out_q.data;
    assign bus.out_tag            = out_q.tag;
    assign bus.out_serialnum      = out_q.serialnum;
    assign bus.out_was_joined     = out_q.was_joined;
    assign bus.out_last_processed = (state_q == S_DONE);
    assign bus.busy               = work;

`ifdef PHJ_ARB_STATS_EN
    logic [NUM_IN-1:0][31:0] gc_q;

    // per-lane handshake counters, frozen once the stream ends
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gc_q <= '0;
        end else if (state_q != S_DONE) begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (bus.in_valid[i] & in_ready[i])
                    gc_q[i] <= gc_q[i] + 32'd1;
            end
        end
    end

    assign bus.grant_count = gc_q;
`endif

endmodule
